// File: rtl/larpix_cmd_pkg.sv
// Shared LArPix command definitions: packet declare codes, field positions, FSM states.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package larpix_cmd_pkg;

  localparam logic [1:0]  PKT_DATA   = 2'b01;
  localparam logic [1:0]  PKT_CFG_WR = 2'b10;
  localparam logic [1:0]  PKT_CFG_RD = 2'b11;

  localparam int DECL_LSB  = 0;
  localparam int CHIP_LSB  = 2;
  localparam int ADDR_LSB  = 10;
  localparam int DATA_LSB  = 18;
  localparam int MAGIC_LSB = 26;
  localparam int PAR_BIT   = 63;

  localparam logic [7:0]  GLOBAL_ID = 8'd255;
  localparam logic [31:0] DEF_MAGIC = 32'h8950_4E47;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  // Builds a config packet; reads carry zero data. Bit 63 makes the total 1-count odd.
  function automatic logic [63:0] cfg_packet(input logic        rd,
                                             input logic [7:0]  chip,
                                             input logic [7:0]  addr,
                                             input logic [7:0]  data,
                                             input logic [31:0] magic = DEF_MAGIC);
    logic [63:0] pkt;
    pkt                  = '0;
    pkt[DECL_LSB +: 2]   = rd ? PKT_CFG_RD : PKT_CFG_WR;
    pkt[CHIP_LSB +: 8]   = chip;
    pkt[ADDR_LSB +: 8]   = addr;
    pkt[DATA_LSB +: 8]   = rd ? 8'h00 : data;
    pkt[MAGIC_LSB +: 32] = magic;
    pkt[PAR_BIT]         = ~^pkt[62:0];
    return pkt;
  endfunction

endpackage

// File: rtl/larpix_cmd_arbiter_rr.sv
// Round-robin picker: one-hot grant to the first set req after index 'last'.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides when the grant is taken and moves 'last'.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic [LW-1:0] w_idx;
  logic          w_found;

  // Scan last+1 .. last+N (mod N) and keep the first requester found.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = LW'((int'(last) + i) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/larpix_cmd_arbiter.sv
// Shares one LArPix UART TX among NREQ requesters; one packet in flight at a time.
// Latency: grant same cycle as req in IDLE, ld_tx_data next cycle if tx_busy is low.
// Backpressure: holds in LOAD while tx_busy; optional post-packet gap via LARPIX_CMD_GAP_EN.
module larpix_cmd_arbiter
  import larpix_cmd_pkg::*;
#(
  parameter int          NREQ         = 4,
  parameter int          WIDTH        = 64,
  parameter logic [31:0] MAGIC        = 32'h8950_4E47,
  parameter int          BUSY_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_req_rd,
  input  logic [NREQ*8-1:0] i_req_chip_id,
  input  logic [NREQ*8-1:0] i_req_addr,
  input  logic [NREQ*8-1:0] i_req_data,
  output logic [NREQ-1:0]   o_grant,
  output logic [WIDTH-1:0]  o_tx_data,
  output logic              o_ld_tx_data,
  input  logic              i_tx_busy,
  output logic              o_cmd_done,
  output logic              o_timeout_err,
  output logic              o_active,
  output logic [15:0]       o_pkt_count
`ifdef LARPIX_CMD_GAP_EN
  ,
  input  logic [15:0]       i_gap_cycles
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_last;
  logic [15:0]     r_to_cnt;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_win;
  logic            w_take;
  logic            w_rd;
  logic [7:0]      w_chip;
  logic [7:0]      w_addr;
  logic [7:0]      w_data;
`ifdef LARPIX_CMD_GAP_EN
  logic [15:0]     r_gap_cnt;
`endif

  rr_arbiter #(.N(NREQ), .LW(IW)) u_rr (
    .req  (i_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  // Decode the one-hot winner into an index and mux out its command fields.
  always_comb begin
    w_win  = '0;
    w_rd   = 1'b0;
    w_chip = '0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_win  = IW'(i);
        w_rd   = i_req_rd[i];
        w_chip = i_req_chip_id[i*8 +: 8];
        w_addr = i_req_addr[i*8 +: 8];
        w_data = i_req_data[i*8 +: 8];
      end
    end
  end

  // Next state and the single-cycle strobes; strobes are suppressed while reset is held.
  always_comb begin
    w_next        = r_state;
    w_take        = 1'b0;
    o_ld_tx_data  = 1'b0;
    o_cmd_done    = 1'b0;
    o_timeout_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_take = 1'b1;
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!i_tx_busy) begin
          o_ld_tx_data = 1'b1;
          w_next       = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_next = ST_WAIT_DONE;
        end else if (r_to_cnt == 16'(BUSY_TIMEOUT - 1)) begin
          o_timeout_err = 1'b1;
          w_next        = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          o_cmd_done = 1'b1;
`ifdef LARPIX_CMD_GAP_EN
          w_next     = ST_GAP;
`else
          w_next     = ST_IDLE;
`endif
        end
      end
`ifdef LARPIX_CMD_GAP_EN
      ST_GAP: begin
        if (r_gap_cnt <= 16'd1) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
    if (i_reset) begin
      w_take        = 1'b0;
      o_ld_tx_data  = 1'b0;
      o_cmd_done    = 1'b0;
      o_timeout_err = 1'b0;
    end
  end

  assign o_grant  = w_take ? w_gnt : '0;
  assign o_active = (r_state != ST_IDLE);

  // State, round-robin pointer, captured packet, packet counter and timers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_last      <= IW'(NREQ - 1);
      o_tx_data   <= '0;
      o_pkt_count <= '0;
      r_to_cnt    <= '0;
`ifdef LARPIX_CMD_GAP_EN
      r_gap_cnt   <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_last    <= w_win;
        o_tx_data <= WIDTH'(cfg_packet(w_rd, w_chip, w_addr, w_data, MAGIC));
      end
      if (o_cmd_done) o_pkt_count <= o_pkt_count + 16'd1;
      r_to_cnt <= (r_state == ST_WAIT_BUSY) ? r_to_cnt + 16'd1 : 16'd0;
`ifdef LARPIX_CMD_GAP_EN
      if (o_cmd_done)              r_gap_cnt <= i_gap_cycles;
      else if (r_state == ST_GAP)  r_gap_cnt <= r_gap_cnt - 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_larpix_cmd_arbiter.sv
// Directed bench for larpix_cmd_arbiter with a behavioural UART busy stub.
// Latency: n/a.
// Backpressure: stub raises tx_busy the cycle after each load for BUSY_LEN cycles.
module tb_larpix_cmd_arbiter;

  localparam int NREQ     = 4;
  localparam int BT       = 16;
  localparam int BUSY_LEN = 6;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [NREQ-1:0]   i_req = '0;
  logic [NREQ-1:0]   i_req_rd = '0;
  logic [NREQ*8-1:0] i_req_chip_id = '0;
  logic [NREQ*8-1:0] i_req_addr = '0;
  logic [NREQ*8-1:0] i_req_data = '0;
  logic              i_tx_busy = 1'b0;
  logic [NREQ-1:0]   o_grant;
  logic [63:0]       o_tx_data;
  logic              o_ld_tx_data, o_cmd_done, o_timeout_err, o_active;
  logic [15:0]       o_pkt_count;
`ifdef LARPIX_CMD_GAP_EN
  logic [15:0]       i_gap_cycles = '0;
`endif

  always #5 clk = ~clk;

  larpix_cmd_arbiter #(.NREQ(NREQ), .WIDTH(64), .MAGIC(32'h8950_4E47), .BUSY_TIMEOUT(BT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_req_rd(i_req_rd),
    .i_req_chip_id(i_req_chip_id), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_grant(o_grant), .o_tx_data(o_tx_data), .o_ld_tx_data(o_ld_tx_data),
    .i_tx_busy(i_tx_busy), .o_cmd_done(o_cmd_done), .o_timeout_err(o_timeout_err),
    .o_active(o_active), .o_pkt_count(o_pkt_count)
`ifdef LARPIX_CMD_GAP_EN
    , .i_gap_cycles(i_gap_cycles)
`endif
  );

  // UART stub: load seen at negedge starts a busy burst; reset clears it.
  int   stub_cnt   = 0;
  logic stub_mute  = 1'b0;
  logic force_busy = 1'b0;
  logic ld_q       = 1'b0;
  always @(negedge clk) ld_q = o_ld_tx_data;
  always @(posedge clk) begin
    #1;
    if (i_reset) stub_cnt = 0;
    else if (ld_q && !stub_mute) stub_cnt = BUSY_LEN;
    if (stub_cnt > 0) begin
      i_tx_busy = 1'b1;
      stub_cnt  = stub_cnt - 1;
    end else begin
      i_tx_busy = force_busy;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_fields(input int k, input logic rd, input logic [7:0] chip,
                            input logic [7:0] addr, input logic [7:0] data);
    i_req_rd[k]              = rd;
    i_req_chip_id[k*8 +: 8]  = chip;
    i_req_addr[k*8 +: 8]     = addr;
    i_req_data[k*8 +: 8]     = data;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_active && n < 80) begin
      tick(); #1; n++;
    end
    chk(name, o_active, 1'b0);
  endtask

  // Full single-requester transaction; ends one cycle after cmd_done.
  task automatic do_txn(input int k, input logic rd, input logic [7:0] chip, input logic [7:0] addr,
                        input logic [7:0] data, input logic [25:0] exp_low, input int exp_cnt);
    int n;
    int lds;
    tick();
    set_fields(k, rd, chip, addr, data);
    i_req[k] = 1'b1;
    #1;
    n = 0;
    while (o_grant == '0 && n < 10) begin
      tick(); #1; n++;
    end
    chk("grant", o_grant, 64'(4'b0001 << k));
    tick();
    i_req[k] = 1'b0;
    #1;
    chk("ld_latency", o_ld_tx_data, 1'b1);
    chk("tx_low", o_tx_data[25:0], exp_low);
    chk("tx_magic", o_tx_data[57:26], 32'h8950_4E47);
    chk("tx_pad", o_tx_data[62:58], 5'd0);
    chk("tx_parity_odd", 64'($countones(o_tx_data) % 2), 1);
    n   = 0;
    lds = 0;
    do begin
      tick(); #1; n++;
      if (o_ld_tx_data) lds++;
    end while (!o_cmd_done && n < 40);
    chk("cmd_done", o_cmd_done, 1'b1);
    chk("extra_ld", 64'(lds), 0);
    chk("cnt_before", o_pkt_count, 64'(exp_cnt - 1));
    tick(); #1;
    chk("cnt_after", o_pkt_count, 64'(exp_cnt));
`ifndef LARPIX_CMD_GAP_EN
    chk("idle_after", o_active, 1'b0);
`endif
  endtask

  typedef struct {
    int         k;
    logic       rd;
    logic [7:0] chip;
    logic [7:0] addr;
    logic [7:0] data;
    logic [25:0] exp_low;
  } vec_t;

  vec_t vt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int         n;
    int         dn;
    int         ovl;
    logic [3:0] order[$];
    logic [3:0] exp_order[6];

    vt[0] = '{0, 1'b0, 8'h10, 8'h01, 8'hA5, {8'hA5, 8'h01, 8'h10, 2'b10}};
    vt[1] = '{2, 1'b1, 8'hFF, 8'h0A, 8'h77, {8'h00, 8'h0A, 8'hFF, 2'b11}};
    vt[2] = '{1, 1'b0, 8'h00, 8'hFF, 8'h00, {8'h00, 8'hFF, 8'h00, 2'b10}};
    vt[3] = '{3, 1'b0, 8'hFF, 8'h00, 8'hFF, {8'hFF, 8'h00, 8'hFF, 2'b10}};
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // Reset values
    repeat (3) tick();
    #1;
    chk("rst_grant", o_grant, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_ld", o_ld_tx_data, 0);
    chk("rst_done", o_cmd_done, 0);
    chk("rst_timeout", o_timeout_err, 0);
    chk("rst_active", o_active, 0);
    chk("rst_count", o_pkt_count, 0);
    i_reset = 1'b0;

    // Table of single-requester commands
    for (int i = 0; i < 4; i++)
      do_txn(vt[i].k, vt[i].rd, vt[i].chip, vt[i].addr, vt[i].data, vt[i].exp_low, i + 1);
    wait_idle("idle_after_table");

    // Fairness: all requesters held; pointer was left at 3 so order starts at 0
    tick();
    i_req = 4'hF;
    n = 0; dn = 0; ovl = 0;
    while (order.size() < 6 && n < 400) begin
      #1;
      if (o_grant != '0) order.push_back(o_grant);
      if (o_ld_tx_data && i_tx_busy) ovl++;
      if (o_cmd_done) dn++;
      tick(); n++;
    end
    i_req = '0;
    n = 0;
    #1;
    while (o_active && n < 80) begin
      if (o_ld_tx_data && i_tx_busy) ovl++;
      if (o_cmd_done) dn++;
      tick(); #1; n++;
    end
    chk("fair_count", 64'(order.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) chk("fair_order", order[i], exp_order[i]);
    chk("fair_overlap", 64'(ovl), 0);
    chk("fair_done", 64'(dn), 6);
    chk("fair_pkt_count", o_pkt_count, 10);

    // Spurious busy in IDLE: grant still happens, load waits for busy to clear
    force_busy = 1'b1;
    tick();
    set_fields(1, 1'b0, 8'h22, 8'h33, 8'h44);
    i_req[1] = 1'b1;
    #1;
    chk("spur_grant", o_grant, 4'b0010);
    tick(); i_req = '0; #1;
    chk("spur_hold_ld", o_ld_tx_data, 0);
    tick(); #1;
    chk("spur_hold_ld2", o_ld_tx_data, 0);
    chk("spur_active", o_active, 1);
    force_busy = 1'b0;
    tick(); #1;
    chk("spur_ld", o_ld_tx_data, 1);
    chk("spur_tx_low", o_tx_data[25:0], {8'h44, 8'h33, 8'h22, 2'b10});
    wait_idle("spur_idle");
    chk("spur_count", o_pkt_count, 11);

    // Timeout: stub never raises busy
    stub_mute = 1'b1;
    tick();
    i_req[2] = 1'b1;
    #1;
    chk("to_grant", o_grant, 4'b0100);
    tick(); i_req = '0; #1;
    chk("to_ld", o_ld_tx_data, 1);
    n = 0; dn = 0;
    do begin
      tick(); #1; n++;
      if (o_cmd_done) dn++;
    end while (!o_timeout_err && n < 40);
    chk("to_cycles", 64'(n), BT);
    chk("to_no_done", 64'(dn), 0);
    tick(); #1;
    chk("to_idle", o_active, 0);
    chk("to_count", o_pkt_count, 11);
    stub_mute = 1'b0;

`ifdef LARPIX_CMD_GAP_EN
    // Gap: five GAP cycles between cmd_done and the next grant
    i_gap_cycles = 16'd5;
    do_txn(0, 1'b0, 8'h01, 8'h02, 8'h03, {8'h03, 8'h02, 8'h01, 2'b10}, 12);
    i_req[0] = 1'b1;
    #1;
    n = 1;
    while (o_grant == '0 && n < 30) begin
      tick(); #1; n++;
    end
    chk("gap_idle_cycles", 64'(n - 1), 5);
    tick(); i_req = '0;
    i_gap_cycles = 16'd0;
    wait_idle("gap_idle");
`endif

    // Reset while in WAIT_DONE
    tick();
    i_req[1] = 1'b1;
    #1;
    chk("mid_grant", o_grant, 4'b0010);
    tick(); i_req = '0; #1;
    n = 0;
    while (!i_tx_busy && n < 20) begin
      tick(); #1; n++;
    end
    tick(); #1;
    chk("mid_active", o_active, 1);
    i_reset = 1'b1;
    tick(); #1;
    chk("mid_rst_grant", o_grant, 0);
    chk("mid_rst_tx", o_tx_data, 0);
    chk("mid_rst_ld", o_ld_tx_data, 0);
    chk("mid_rst_done", o_cmd_done, 0);
    chk("mid_rst_timeout", o_timeout_err, 0);
    chk("mid_rst_active", o_active, 0);
    chk("mid_rst_count", o_pkt_count, 0);
    i_reset = 1'b0;
    i_req   = 4'b1001;
    #1;
    chk("mid_next_winner", o_grant, 4'b0001);
    tick(); i_req = '0;
    #1;
    wait_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/larpix_cmd_arbiter.md
# larpix_cmd_arbiter

Round-robin command scheduler that shares the FPGA-side LArPix UART transmitter between several command requesters, such as a config-write sequencer, a config-read poller and a broadcast initializer. It sits between those requesters and `uart_tx_fpga`. It builds a 64-bit LArPix configuration packet from the granted request, computes parity, and drives the `ld_tx_data`/`tx_busy` handshake. It guarantees exactly one packet in flight on POSI at any time.

## Interface
- `NREQ`, 4: number of requesters, range 2–8.
- `WIDTH`, 64: packet width; must match `uart_tx_fpga`.
- `MAGIC`, 32'h8950_4E47: magic number placed in bits [57:26].
- `BUSY_TIMEOUT`, 16: cycles allowed after load for `tx_busy` to rise.
- `clk`, in, 1: system clock, same clock as the UART.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, NREQ: request level per requester; held until granted.
- `req_rd`, in, NREQ: 1 = config read (declare 2'b11), 0 = config write (declare 2'b10).
- `req_chip_id`, in, NREQ×8: target chip ID; 255 is the global broadcast.
- `req_addr`, in, NREQ×8: register map address.
- `req_data`, in, NREQ×8: register data; ignored for reads (forced 0).
- `grant`, out, NREQ: one-hot, one-cycle pulse when a request is captured.
- `tx_data`, out, WIDTH: packet to `uart_tx_fpga`.
- `ld_tx_data`, out, 1: one-cycle load strobe.
- `tx_busy`, in, 1: UART busy flag.
- `cmd_done`, out, 1: one-cycle pulse when the UART finishes the packet.
- `timeout_err`, out, 1: one-cycle pulse when `tx_busy` fails to rise in time.
- `active`, out, 1: high in every state except IDLE.
- `pkt_count`, out, 16: packets completed; wraps from 0xFFFF to 0.

## Operation
- **Packet layout:**
  - [1:0] declare
  - [9:2] chip_id
  - [17:10] addr
  - [25:18] data
  - [57:26] MAGIC
  - [62:58] 0
  - [63] odd parity over [62:0], so the total number of 1s is odd.
- **FSM states:** IDLE → LOAD → WAIT_BUSY → WAIT_DONE → (GAP) → IDLE.
- **IDLE:**
  - If any `req` bit is set, select a winner round-robin.
  - Search starts at `last_grant+1` modulo NREQ.
  - On the same cycle: assert `grant[winner]`, register the packet into `tx_data`, record `last_grant` = winner, and go to LOAD.
- **LOAD:** Wait until `tx_busy` = 0. In that cycle assert `ld_tx_data` = 1 for exactly one cycle and go to WAIT_BUSY.
- **WAIT_BUSY:**
  - When `tx_busy` = 1, go to WAIT_DONE.
  - If `BUSY_TIMEOUT` cycles pass without `tx_busy` = 1: pulse `timeout_err`, drop the packet (no `cmd_done`, no count), and go to IDLE.
- **WAIT_DONE:** On `tx_busy` falling to 0, pulse `cmd_done`, increment `pkt_count`, and go to GAP (if compiled in) or IDLE.
- **Requester contract:** Fields are captured only at grant. A requester must deassert `req` in the cycle after its grant, or it is re-arbitrated as a new command.
- **Single requester:** A lone requester is served back-to-back; fairness applies only when several `req` bits are set together.
- **Dropped requests:** A `req` deasserted before grant is silently dropped.
- **`tx_data`:** Holds its value until the next grant.

## Timing
- **Reset values:** `grant` = 0, `tx_data` = 0, `ld_tx_data` = 0, `cmd_done` = 0, `timeout_err` = 0, `active` = 0, `pkt_count` = 0.
  - `last_grant` resets to NREQ−1, so requester 0 wins first.
  - FSM resets to IDLE.
- **Latency:** Request seen in IDLE at cycle N → `grant` at N → `ld_tx_data` at N+1 (if `tx_busy` = 0).
- **Reset mid-operation:** Abandons the packet the next cycle. No `cmd_done` is emitted. The UART is reset separately.
- **Spurious `tx_busy`:** A `tx_busy` = 1 seen in IDLE is ignored; the FSM waits in LOAD until it clears.
- **Timeout counter:** Starts at 0 on entry to WAIT_BUSY and fires when it reaches `BUSY_TIMEOUT`−1.

## Configuration
- **Macro:** `LARPIX_CMD_GAP_EN`.
- **When defined:**
  - Adds input `gap_cycles` (16 bits), sampled on entry to GAP.
  - The FSM holds GAP for that many cycles before returning to IDLE, keeping `active` = 1.
  - `gap_cycles` = 0 gives 1 GAP cycle.
- **When undefined:** No GAP state and no `gap_cycles` port; WAIT_DONE goes directly to IDLE.

## Structure
- **Package `larpix_cmd_pkg`:**
  - declare encodings PKT_DATA = 2'b01, PKT_CFG_WR = 2'b10, PKT_CFG_RD = 2'b11
  - field bit-position localparams
  - state enum
  - GLOBAL_ID = 8'd255
  - function `cfg_packet(rd, chip, addr, data)` returning the parity-filled word
- **Sub-module `rr_arbiter`:** parameterized by N, with inputs `req` and `last`, output `gnt` one-hot. Purely combinational; the pointer is held in the parent.

## Test plan
- **Single write:** requester 0 write, chip 16, addr 1, data 0xA5 → `tx_data[25:0]` = {8'hA5, 8'h01, 8'h10, 2'b10}, MAGIC in [57:26], parity odd; one `ld_tx_data` pulse; `cmd_done` after the UART completes; `pkt_count` = 1.
- **Fairness:** all 4 requesters hold `req` continuously → grant order 0, 1, 2, 3, 0, 1; no two packets overlap on `tx_busy`.
- **Read:** requester 2 read, chip 255, addr 10, data 0x77 → declare 2'b11 and [25:18] = 0.
- **Timeout:** stub UART with `tx_busy` stuck at 0 → `timeout_err` fires exactly `BUSY_TIMEOUT` cycles after `ld_tx_data`; FSM returns to IDLE; `pkt_count` unchanged.
- **Reset mid-operation:** `reset` asserted in WAIT_DONE → next cycle all outputs at reset values; no `cmd_done`; requester 0 wins the next grant.
- **Gap (`LARPIX_CMD_GAP_EN` defined):** `gap_cycles` = 5 → exactly 5 idle cycles between `cmd_done` and the next `grant`.
